// File: rtl/fp32_pkg.sv
// fp32_pkg: round-mode codes, exponent bias, special-value fields and FSM state type for the fp32 units
package fp32_pkg;
    localparam logic [1:0] RM_UP = 2'b00;
    localparam logic [1:0] RM_DOWN = 2'b01;
    localparam logic [1:0] RM_NEAR = 2'b10;
    localparam logic [1:0] RM_AWAY = 2'b11;
    localparam int BIAS = 127;
    localparam logic [7:0] EXP_INF = 8'hFF;
    localparam logic [22:0] QNAN_FRAC = 23'h400000;
    localparam logic [22:0] INF_FRAC = 23'h000000;
    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
endpackage

// File: rtl/fp32_round_unit.sv
// fp32_round_unit: combinational W-bit mantissa rounder (mant, guard, sticky, sign, mode -> mant_out, carry)
module fp32_round_unit
    import fp32_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] mant,
    input  logic         guard,
    input  logic         sticky,
    input  logic         sign,
    input  logic [1:0]   mode,
    output logic [W-1:0] mant_out,
    output logic         carry
);
    logic         inc;
    logic [W:0]   sum;
    always_comb begin
        inc = mode == RM_NEAR ? guard & (sticky | mant[0]) :
              mode == RM_AWAY ? guard :
              mode == RM_UP   ? ~sign & (guard | sticky) :
              mode == RM_DOWN ? sign & (guard | sticky) : 1'b0;
        sum = {1'b0, mant} + {{W{1'b0}}, inc};
        carry = sum[W];
        mant_out = carry ? sum[W:1] : sum[W-1:0];
    end
endmodule

// File: rtl/fp32_divider.sv
// fp32_divider: multi-cycle IEEE-754 single divider (start/A/B/round_mode in; busy/done/resultDiv/errorDiv/overflowDiv out)
module fp32_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  round_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] resultDiv,
    output logic        errorDiv,
    output logic        overflowDiv
);
    state_t             state;
    logic [4:0]         cnt;
    logic [23:0]        dvs;
    logic [24:0]        rem;
    logic [26:0]        q;
    logic signed [9:0]  exp_r;
    logic               sign_r;
    logic [1:0]         mode_r;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in, special, invalid, sp_err;
    logic [31:0]        sp_res;
    logic               rem_ge;
    logic [24:0]        rem_sub;
    logic [26:0]        norm;
    logic signed [9:0]  exp_n;
    logic signed [9:0]  exp_f;
    logic [23:0]        mant_r;
    logic               carry;
    logic               ovf;
    logic               unf;
    logic [30:0]        mag;
    always_comb begin
        a_zero = A[30:23] == 8'd0;
        b_zero = B[30:23] == 8'd0;
        a_nan = A[30:23] == EXP_INF && A[22:0] != 23'd0;
        b_nan = B[30:23] == EXP_INF && B[22:0] != 23'd0;
        a_inf = A[30:23] == EXP_INF && A[22:0] == 23'd0;
        b_inf = B[30:23] == EXP_INF && B[22:0] == 23'd0;
        sign_in = A[31] ^ B[31];
        special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        invalid = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        sp_res = invalid ? {sign_in, EXP_INF, QNAN_FRAC} :
                 (a_inf | b_zero) ? {sign_in, EXP_INF, INF_FRAC} : {sign_in, 31'd0};
        sp_err = invalid | (b_zero & ~a_inf);
    end
    always_comb begin
        rem_ge = rem >= {1'b0, dvs};
        rem_sub = rem_ge ? rem - {1'b0, dvs} : rem;
        norm = q[26] ? q : {q[25:0], 1'b0};
        exp_n = q[26] ? exp_r : exp_r - 10'sd1;
    end
    fp32_round_unit #(.W(24)) u_round (
        .mant     (norm[26:3]),
        .guard    (norm[2]),
        .sticky   (|norm[1:0] | |rem),
        .sign     (sign_r),
        .mode     (mode_r),
        .mant_out (mant_r),
        .carry    (carry)
    );
    always_comb begin
        exp_f = exp_n + $signed({9'd0, carry});
        ovf = exp_f >= 10'sd255;
        unf = exp_f <= 10'sd0;
        // the hidden bit of mant_r carries into the exponent field, so bias the exponent down by one
        mag = {exp_f[7:0] - 8'd1, 23'd0} + {7'd0, mant_r};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            dvs <= '0;
            rem <= '0;
            q <= '0;
            exp_r <= '0;
            sign_r <= 1'b0;
            mode_r <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            resultDiv <= '0;
            errorDiv <= 1'b0;
            overflowDiv <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign_r <= sign_in;
                    mode_r <= round_mode;
                    dvs <= {1'b1, B[22:0]};
                    rem <= {2'b01, A[22:0]};
                    q <= '0;
                    cnt <= '0;
                    exp_r <= 10'($signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + BIAS);
                    if (special) begin
                        resultDiv <= sp_res;
                        errorDiv <= sp_err;
                        overflowDiv <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end else begin
                        busy <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    q <= {q[25:0], rem_ge};
                    rem <= rem_sub << 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd26) state <= ROUND;
                end
                ROUND: begin
                    resultDiv <= ovf ? {sign_r, EXP_INF, INF_FRAC} : unf ? {sign_r, 31'd0} : {sign_r, mag};
                    errorDiv <= ovf;
                    overflowDiv <= ovf;
                    busy <= 1'b0;
                    done <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: directed self-checking bench for fp32_divider
module tb_fp32_divider;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [1:0]  round_mode = 2'b10;
    logic        busy;
    logic        done;
    logic [31:0] resultDiv;
    logic        errorDiv;
    logic        overflowDiv;
    int          errors = 0;
    int          checks = 0;
    int          lat;
    int          dones;
    logic        busy1;
    fp32_divider dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .round_mode  (round_mode),
        .busy        (busy),
        .done        (done),
        .resultDiv   (resultDiv),
        .errorDiv    (errorDiv),
        .overflowDiv (overflowDiv)
    );
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        @(negedge clk);
        A = a;
        B = b;
        round_mode = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 32'hDEADBEEF;
        B = 32'h00000000;
        round_mode = ~m;
    endtask
    task automatic wait_done(output int l, output logic b1);
        @(negedge clk);
        l = 1;
        b1 = busy;
        while (!done && l < 60) begin
            @(negedge clk);
            l++;
        end
    endtask
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m, output int l, output logic b1);
        launch(a, b, m);
        wait_done(l, b1);
    endtask
    initial begin
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", resultDiv, 32'h0);
        chk("reset err", 32'(errorDiv), 32'd0);
        chk("reset ovf", 32'(overflowDiv), 32'd0);
        reset_n = 1'b1;
        run(32'h40C00000, 32'h40000000, 2'b10, lat, busy1);
        chk("6/2 latency", 32'(lat), 32'd29);
        chk("6/2 busy", 32'(busy1), 32'd1);
        chk("6/2 result", resultDiv, 32'h40400000);
        chk("6/2 err", 32'(errorDiv), 32'd0);
        chk("6/2 ovf", 32'(overflowDiv), 32'd0);
        @(negedge clk);
        chk("done pulse width", 32'(done), 32'd0);
        chk("result hold", resultDiv, 32'h40400000);
        run(32'h3F800000, 32'h40400000, 2'b10, lat, busy1);
        chk("1/3 near", resultDiv, 32'h3EAAAAAB);
        chk("1/3 near latency", 32'(lat), 32'd29);
        run(32'h3F800000, 32'h40400000, 2'b01, lat, busy1);
        chk("1/3 down", resultDiv, 32'h3EAAAAAA);
        run(32'h3F800000, 32'h40400000, 2'b00, lat, busy1);
        chk("1/3 up", resultDiv, 32'h3EAAAAAB);
        run(32'h3F800000, 32'h00000000, 2'b10, lat, busy1);
        chk("1/0 latency", 32'(lat), 32'd1);
        chk("1/0 result", resultDiv, 32'h7F800000);
        chk("1/0 err", 32'(errorDiv), 32'd1);
        chk("1/0 ovf", 32'(overflowDiv), 32'd0);
        run(32'h00000000, 32'h00000000, 2'b10, lat, busy1);
        chk("0/0 result", resultDiv, 32'h7FC00000);
        chk("0/0 err", 32'(errorDiv), 32'd1);
        run(32'h7F000000, 32'h3E800000, 2'b10, lat, busy1);
        chk("overflow result", resultDiv, 32'h7F800000);
        chk("overflow ovf", 32'(overflowDiv), 32'd1);
        chk("overflow err", 32'(errorDiv), 32'd1);
        run(32'h00800000, 32'h7F000000, 2'b10, lat, busy1);
        chk("underflow result", resultDiv, 32'h00000000);
        chk("underflow err", 32'(errorDiv), 32'd0);
        chk("underflow ovf", 32'(overflowDiv), 32'd0);
        run(32'hC0C00000, 32'h40000000, 2'b10, lat, busy1);
        chk("-6/2 result", resultDiv, 32'hC0400000);
        launch(32'h40C00000, 32'h40000000, 2'b10);
        repeat (5) @(negedge clk);
        A = 32'h3F800000;
        B = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 6;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("ignored start latency", 32'(lat), 32'd29);
        chk("ignored start result", resultDiv, 32'h40400000);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("no queued op", 32'(dones), 32'd0);
        chk("result after ignore", resultDiv, 32'h40400000);
        launch(32'h3F800000, 32'h40400000, 2'b10);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", resultDiv, 32'h0);
        chk("abort err", 32'(errorDiv), 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        run(32'h40C00000, 32'h40000000, 2'b10, lat, busy1);
        chk("post-abort latency", 32'(lat), 32'd29);
        chk("post-abort result", resultDiv, 32'h40400000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp32_divider.md
FP32_DIVIDER -- requirements
Module: fp32_divider

Interface
REQ-001 The block SHALL expose these ports:
  - clk  input  1  rising-edge clock.
  - reset_n  input  1  reset, asynchronous, active-low.
  - start  input  1  request pulse; sampled only in IDLE.
  - A  input  32  IEEE-754 single-precision dividend.
  - B  input  32  IEEE-754 single-precision divisor.
  - round_mode  input  2  rounding mode: 00 toward +inf, 01 toward -inf, 10 nearest-even, 11 ties-away-from-zero.
  - busy  output  1  high from the cycle after start acceptance until done.
  - done  output  1  one-cycle pulse when the result is valid.
  - resultDiv  output  32  quotient A/B.
  - errorDiv  output  1  invalid operation, divide-by-zero, or overflow.
  - overflowDiv  output  1  exponent overflow to infinity.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-003 The block SHALL latch A, B and round_mode on the start cycle in IDLE; input changes afterwards SHALL have no effect on the current operation.
REQ-004 The block SHALL ignore start when not in IDLE (no queueing).
REQ-005 The state machine SHALL have states IDLE, CALC, ROUND and DONE: IDLE->CALC on start; CALC->ROUND after 27 iterations; ROUND->DONE; DONE->IDLE unconditionally.
REQ-006 A special operand SHALL take IDLE->DONE directly, giving done one cycle after start.
REQ-007 A normal operation SHALL assert done exactly 29 cycles after the start cycle.
REQ-008 The result sign SHALL be A[31]^B[31] for every result, including NaN.
REQ-009 Denormal inputs (E==0) SHALL be treated as signed zero.
REQ-010 Special cases SHALL produce:
  - NaN input, 0/0 or inf/inf -> {S,0xFF,0x400000}, errorDiv=1, overflowDiv=0.
  - finite nonzero/0 -> {S,0xFF,0}, errorDiv=1, overflowDiv=0.
  - inf/finite -> inf, both flags 0.
  - 0/nonzero-or-inf and finite/inf -> signed zero, both flags 0.
REQ-011 CALC SHALL perform restoring division of {1,F1} by {1,F2}, one quotient bit per cycle, yielding a 27-bit quotient q[26:0]; the sticky bit SHALL be the OR of the final remainder bits.
REQ-012 The exponent SHALL be computed as E1-E2+127 in at least 10-bit signed arithmetic; when q[26]==0 the quotient SHALL be shifted left 1 and the exponent decremented by 1.
REQ-013 ROUND SHALL form a 24-bit mantissa plus guard and sticky and increment the mantissa when:
  - mode 10: guard & (sticky | lsb);
  - mode 11: guard;
  - mode 00: S==0 & (guard|sticky);
  - mode 01: S==1 & (guard|sticky).
REQ-014 A rounding carry-out SHALL shift the mantissa right 1 and increment the exponent.
REQ-015 A final exponent >=255 SHALL give {S,0xFF,0} with overflowDiv=1 and errorDiv=1.
REQ-016 A final exponent <=0 SHALL give signed zero with both flags 0.
REQ-017 resultDiv, errorDiv and overflowDiv SHALL update in the DONE cycle and hold until the next DONE.

Reset
REQ-018 On reset_n low the block SHALL enter IDLE with busy=0, done=0, resultDiv=0, errorDiv=0, overflowDiv=0 and all datapath registers cleared.
REQ-019 Reset asserted mid-operation SHALL abort the operation without producing a done pulse; after release the block SHALL accept a new start.

Structure
REQ-020 A shared package fp32_pkg SHALL hold the round-mode constants, the BIAS=127 constant, the QNAN/INF field constants and the state enum type.
REQ-021 The rounding logic SHALL be a combinational sub-module fp32_round_unit, parameterized by mantissa width, and reusable by the multiplier.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - 0x40C00000/0x40000000, mode 10 -> 0x40400000, flags 0, done at start+29.
  - 0x3F800000/0x40400000: mode 10 -> 0x3EAAAAAB; mode 01 -> 0x3EAAAAAA; mode 00 -> 0x3EAAAAAB.
  - 0x3F800000/0x00000000 -> 0x7F800000, errorDiv=1, overflowDiv=0, done at start+1; 0x00000000/0x00000000 -> 0x7FC00000, errorDiv=1.
  - 0x7F000000/0x3E800000 -> 0x7F800000, overflowDiv=1, errorDiv=1; 0x00800000/0x7F000000 -> 0x00000000, flags 0.
  - Second start during busy is ignored and the first result is unchanged; reset_n pulsed at cycle 10 of CALC -> no done pulse, outputs 0, next start completes normally.
